sys_arr_result_drain: RTL

Downstream drain stage for one row of FP32 multiply-add PEs in the DSP systolic array. It waits until every PE in the row has held its computation-done flag for a programmable settle window, then snapshots all N accumulators and error flags in a single cycle. It serialises the snapshot onto one AXI-Stream master port, column 0 first, and reports a sticky error summary for the row.

---
 rtl/sys_arr_result_drain.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sys_arr_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : sys_arr_result_drain
// Brief    : Drains one systolic-array row of FP32 accumulators. Waits for
//            comp_done to settle, snapshots the row, streams it over AXI-S.
// Revision : 1.0 - initial release
// ============================================================================
module sys_arr_result_drain #(
    parameter int N      = 4,
    parameter int SETTLE = 8,
    parameter int CNT_W  = $clog2(SETTLE + 1)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [32*N-1:0]      pe_accum_sum,
    input  logic [N-1:0]         pe_comp_done,
    input  logic [2*N-1:0]       pe_user,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [1:0]           m_tuser,
    output logic [$clog2(N)-1:0] m_tid,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err_sticky
);

    localparam int c_IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_STREAM  = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_done;
    logic [1:0]           r_err;
    logic [31:0]          r_shadow_data [N];
    logic [1:0]           r_shadow_user [N];

    logic                 w_all_done;
    logic                 w_capture;
    logic [1:0]           w_user_or;

    assign w_all_done = &pe_comp_done;
    // Snapshot is taken on the edge that ends the final settle cycle, so the
    // captured row is exactly what was present while all PEs reported done.
    assign w_capture  = (r_state == S_SETTLE) && w_all_done && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_user_or = 2'b00;
        for (int i = 0; i < N; i++) begin
            w_user_or = w_user_or | r_shadow_user[i];
        end
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_shadow
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    r_shadow_data[g] <= 32'd0;
                    r_shadow_user[g] <= 2'b00;
                end else if (w_capture) begin
                    r_shadow_data[g] <= pe_accum_sum[32*g +: 32];
                    r_shadow_user[g] <= pe_user[2*g +: 2];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                    end
                end
                S_SETTLE: begin
                    // Any single-cycle drop restarts the window: PEs blink
                    // comp_done low between MACs.
                    if (!w_all_done) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    r_err   <= r_err | w_user_or;
                    r_idx   <= '0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (m_tready) begin
                        if (r_idx == c_IDX_LAST) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stream outputs decode registered state and the shadow bank only.
    assign m_tvalid   = (r_state == S_STREAM);
    assign m_tdata    = r_shadow_data[r_idx];
    assign m_tuser    = r_shadow_user[r_idx];
    assign m_tid      = r_idx;
    assign m_tlast    = m_tvalid && (r_idx == c_IDX_LAST);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err_sticky = r_err;

endmodule
`default_nettype wire
